// File: rtl/neuron_seq.sv
// Time-multiplexed neuron: o = act(sat(sum(a[i]*w[i]) + bias)), one MAC per cycle.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   in_valid / in_ready      input vector handshake (a[], w[], bias)
//   a[], w[], bias           signed fixed-point operands, FRAC_BITS fractional bits
//   out_valid / out_ready    result handshake
//   o                        activated, saturated result
//   busy                     high whenever the FSM is not IDLE
module neuron_seq #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 0,
    parameter int unsigned NUM_INPUTS = 4,
    parameter bit          RELU_EN    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] a [NUM_INPUTS],
    input  logic signed [DATA_WIDTH-1:0] w [NUM_INPUTS],
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] o,
    output logic                         busy
);

    localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH + $clog2(NUM_INPUTS) + 1;
    localparam int unsigned IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        FINISH = 2'd2,
        HOLD   = 2'd3
    } state_e;

    state_e                        state_q, state_d;
    logic        [IDX_W-1:0]       idx_q, idx_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]  o_q, o_d;
    logic                          out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0]  a_q [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0]  w_q [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0]  bias_q;
    logic                          load_c;

    logic signed [2*DATA_WIDTH-1:0] prod_c;
    logic signed [ACC_WIDTH-1:0]    bias_ext_c;
    logic signed [ACC_WIDTH-1:0]    sum_c;
    logic signed [ACC_WIDTH-1:0]    shr_c;
    logic signed [DATA_WIDTH-1:0]   sat_c;
    logic signed [DATA_WIDTH-1:0]   act_c;

    // Single shared multiplier over the registered operand vectors
    assign prod_c     = a_q[idx_q] * w_q[idx_q];
    // Bias is aligned to the product's 2*FRAC_BITS scale before the add
    assign bias_ext_c = ACC_WIDTH'(bias_q) <<< FRAC_BITS;
    assign sum_c      = acc_q + bias_ext_c;
    // Arithmetic shift back to the output scale; rounds toward -inf
    assign shr_c      = sum_c >>> FRAC_BITS;

    // Saturation to the output range, then optional ReLU
    always_comb begin
        if (shr_c > SAT_MAX) begin
            sat_c = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
        end else if (shr_c < SAT_MIN) begin
            sat_c = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        end else begin
            sat_c = shr_c[DATA_WIDTH-1:0];
        end
        act_c = (RELU_EN && sat_c[DATA_WIDTH-1]) ? '0 : sat_c;
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        o_d         = o_q;
        out_valid_d = out_valid_q;
        load_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_c  = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_WIDTH'(prod_c);
                if (idx_q == IDX_W'(NUM_INPUTS - 1)) begin
                    idx_d   = '0;
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            FINISH: begin
                o_d         = act_c;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            o_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            o_q         <= o_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operand capture; contents are only consumed after a fresh load
    always_ff @(posedge clk) begin
        if (load_c) begin
            a_q    <= a;
            w_q    <= w;
            bias_q <= bias;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign o         = o_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_seq.sv
// Scoreboard bench for neuron_seq: two instances share stimulus (N=4),
// one integer/ReLU, one FRAC_BITS=8/identity.
module tb_neuron_seq;

    localparam int DW = 16;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic signed [DW-1:0] a [N];
    logic signed [DW-1:0] w [N];
    logic signed [DW-1:0] bias;

    logic                 in_ready_w  [2];
    logic                 out_valid_w [2];
    logic                 busy_w      [2];
    logic signed [DW-1:0] o_w         [2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit rand_rdy = 1'b0;

    logic signed [DW-1:0] exp_q0 [$];
    logic signed [DW-1:0] exp_q1 [$];
    logic signed [DW-1:0] held   [2];
    logic                 ov_prev [2];

    always #5 clk = ~clk;

    neuron_seq #(.DATA_WIDTH(DW), .FRAC_BITS(0), .NUM_INPUTS(N), .RELU_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .a(a), .w(w), .bias(bias), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .o(o_w[0]), .busy(busy_w[0])
    );

    neuron_seq #(.DATA_WIDTH(DW), .FRAC_BITS(8), .NUM_INPUTS(N), .RELU_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .a(a), .w(w), .bias(bias), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .o(o_w[1]), .busy(busy_w[1])
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: exact integer dot product, scaled bias, floor shift, clamp, ReLU
    function automatic logic signed [DW-1:0] model(input logic signed [DW-1:0] va [N],
                                                   input logic signed [DW-1:0] vw [N],
                                                   input logic signed [DW-1:0] vb,
                                                   input int frac, input bit relu);
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(va[i]) * longint'(vw[i]);
        s += longint'(vb) * (longint'(1) << frac);
        s = s >>> frac;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return DW'(s);
    endfunction

    // Scoreboard push on every accepted vector; reset aborts pending results
    always @(posedge clk) begin
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
        end else if (in_valid && in_ready_w[0]) begin
            exp_q0.push_back(model(a, w, bias, 0, 1'b1));
            exp_q1.push_back(model(a, w, bias, 8, 1'b0));
            acc_cyc <= cyc + 1;
        end
        cyc <= cyc + 1;
    end

    // Monitor: pop on each out_valid rise, check latency and hold stability
    always @(negedge clk) begin
        logic signed [DW-1:0] e;
        if (rst) begin
            ov_prev[0] = 1'b0;
            ov_prev[1] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                chk("busy_vs_ready", longint'(busy_w[k]), longint'(!in_ready_w[k]));
                if (out_valid_w[k] && !ov_prev[k]) begin
                    chk("latency", longint'(cyc - acc_cyc), longint'(N + 1));
                    if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk(k == 0 ? "result_int_relu" : "result_frac8", longint'(o_w[k]), longint'(e));
                        held[k] = o_w[k];
                    end
                end else if (out_valid_w[k]) begin
                    chk("hold_stable", longint'(o_w[k]), longint'(held[k]));
                end
                ov_prev[k] = out_valid_w[k];
            end
        end
    end

    // Random consumer backpressure when enabled
    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic signed [DW-1:0] va [N], input logic signed [DW-1:0] vw [N],
                        input logic signed [DW-1:0] vb);
        int t = 0;
        a = va;
        w = vw;
        bias = vb;
        in_valid = 1'b1;
        while (!in_ready_w[0] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("send_timeout", 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || !in_ready_w[0]) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("drain_timeout", 1, 0);
    endtask

    function automatic logic signed [DW-1:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 16'sh7FFF;
            1: return 16'sh8000;
            2: return DW'($signed($urandom_range(0, 40)) - 20);
            default: return DW'($urandom);
        endcase
    endfunction

    logic signed [DW-1:0] ta [N];
    logic signed [DW-1:0] tw [N];

    initial begin
        int t;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        bias = '0;
        for (int i = 0; i < N; i++) begin a[i] = '0; w[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_o", longint'(o_w[k]), 0);
            chk("reset_out_valid", longint'(out_valid_w[k]), 0);
            chk("reset_in_ready", longint'(in_ready_w[k]), 1);
            chk("reset_busy", longint'(busy_w[k]), 0);
        end

        // Directed vectors: plain dot product, positive/negative saturation, fixed-point
        ta = '{16'sd1, 16'sd2, 16'sd3, 16'sd4}; tw = '{16'sd5, 16'sd6, 16'sd7, 16'sd8};
        send(ta, tw, -16'sd10); drain();
        ta = '{16'sh7FFF, 16'sh7FFF, 16'sd0, 16'sd0}; tw = '{16'sh7FFF, 16'sh7FFF, 16'sd0, 16'sd0};
        send(ta, tw, 16'sd0); drain();
        ta = '{16'sh8000, 16'sh8000, 16'sd0, 16'sd0};
        send(ta, tw, 16'sd0); drain();
        ta = '{16'sh0180, 16'sd0, 16'sd0, 16'sd0}; tw = '{16'shFF00, 16'sd0, 16'sd0, 16'sd0};
        send(ta, tw, 16'sh0040); drain();
        ta = '{-16'sd5, 16'sd0, 16'sd0, 16'sd0}; tw = '{16'sd5, 16'sd0, 16'sd0, 16'sd0};
        send(ta, tw, 16'sd5); drain();

        // Backpressure: result held, input ignored, then one transfer
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin ta[i] = rand_val(); tw[i] = rand_val(); end
        send(ta, tw, rand_val());
        t = 0;
        while (!out_valid_w[0] && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) chk("out_valid_timeout", 1, 0);
        for (int c = 0; c < 10; c++) begin
            chk("bp_in_ready", longint'(in_ready_w[0]), 0);
            chk("bp_out_valid", longint'(out_valid_w[1]), 1);
            for (int i = 0; i < N; i++) a[i] = rand_val();
            in_valid = c[0];
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_transfer_done", longint'(out_valid_w[0]), 0);
        chk("bp_in_ready_after", longint'(in_ready_w[0]), 1);
        chk("bp_queue_empty", longint'(exp_q0.size()), 0);

        // Reset during MAC aborts; next vector unaffected by old accumulator
        ta = '{16'sd100, 16'sd200, 16'sd300, 16'sd400}; tw = '{16'sd9, 16'sd9, 16'sd9, 16'sd9};
        send(ta, tw, 16'sd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_o", longint'(o_w[0]), 0);
        chk("abort_out_valid", longint'(out_valid_w[0]), 0);
        chk("abort_in_ready", longint'(in_ready_w[0]), 1);
        repeat (N + 4) @(negedge clk);
        ta = '{16'sd1, 16'sd1, 16'sd1, 16'sd1}; tw = '{16'sd2, 16'sd3, 16'sd4, 16'sd5};
        send(ta, tw, 16'sd0); drain();

        // Randomized stream with random gaps and consumer stalls
        rand_rdy = 1'b1;
        for (int v = 0; v < 150; v++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            for (int i = 0; i < N; i++) begin ta[i] = rand_val(); tw[i] = rand_val(); end
            send(ta, tw, rand_val());
        end
        drain();
        rand_rdy = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("final_queue0_empty", longint'(exp_q0.size()), 0);
        chk("final_queue1_empty", longint'(exp_q1.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
